// File: rtl/key_scan_encoder.sv
`timescale 1ns/1ps
// Front-end for the key-sequence lock: synchronises and debounces four active-low
// buttons, and encodes one accepted single-key press into a 2-bit code with a one-cycle strobe.
module key_scan_encoder #(
    parameter int unsigned CNT_MAX = 1_000_000,
    parameter int unsigned CNT_W   = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_n,
    output logic       key_valid,
    output logic [1:0] key_code,
    output logic       key_err,
    output logic       key_busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRS,
        HELD,
        DEB_REL
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       sync_q, ks;
    logic [3:0]       cand, cand_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             key_valid_nxt, key_err_nxt;
    logic [1:0]       key_code_nxt;
    logic [3:0]       ks_act;
    logic             ks_none, ks_single;

    function automatic logic [1:0] enc(input logic [3:0] k);
        case (k)
            4'b1110: enc = 2'b00;
            4'b1101: enc = 2'b01;
            4'b1011: enc = 2'b10;
            4'b0111: enc = 2'b11;
            default: enc = 2'b00;
        endcase
    endfunction

    // Exactly one pressed key <=> the active-high vector is a nonzero power of two.
    assign ks_act    = ~ks;
    assign ks_none   = (ks_act == '0);
    assign ks_single = !ks_none && ((ks_act & (ks_act - 4'd1)) == '0);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q    <= '1;
            ks        <= '1;
            state     <= IDLE;
            cand      <= '1;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
            key_err   <= 1'b0;
            key_busy  <= 1'b0;
        end else begin
            sync_q    <= key_n;
            ks        <= sync_q;
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_valid <= key_valid_nxt;
            key_code  <= key_code_nxt;
            key_err   <= key_err_nxt;
            key_busy  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        key_valid_nxt = 1'b0;
        key_err_nxt   = 1'b0;
        key_code_nxt  = key_code;
        case (state)
            IDLE: begin
                if (ks_single) begin
                    state_nxt = DEB_PRS;
                    cand_nxt  = ks;
                    cnt_nxt   = '0;
                end
            end
            DEB_PRS: begin
                if (ks == cand) begin
                    if (cnt == CNT_LAST) begin
                        state_nxt     = HELD;
                        key_valid_nxt = 1'b1;
                        key_code_nxt  = enc(cand);
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (ks_none) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt   = IDLE;
                    key_err_nxt = 1'b1;
                end
            end
            HELD: begin
                if (ks_none) begin
                    state_nxt = DEB_REL;
                    cnt_nxt   = '0;
                end
            end
            DEB_REL: begin
                // Any key seen during release debounce is bounce on the held key.
                if (!ks_none) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
